// File: rtl/banked_vector_ram_if.sv
// Request/response bus of the banked vector scratchpad: one request carries
// LANES (address, data) pairs, one in-order response comes back per request.
interface banked_vector_ram_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                         req_valid;
  logic                         req_ready;
  logic [1:0]                   req_op;
  logic [LANES-1:0]             req_mask;
  logic [LANES*ADDR_WIDTH-1:0]  req_addr;
  logic [LANES*DATA_WIDTH-1:0]  req_wdata;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [LANES*DATA_WIDTH-1:0]  rsp_data;
  logic [LANES-1:0]             rsp_mask;
  logic [LANES-1:0]             rsp_err;

  modport master (
    output req_valid, req_op, req_mask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_mask, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_mask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_mask, rsp_err
  );
endinterface

// File: rtl/banked_vector_ram.sv
// Multi-lane vector scratchpad over BANKS single-port RAM banks with read,
// write and accumulate (read-modify-write add returning the old value).
//
// state | meaning
// IDLE  | ready for a request; latches lanes and computes error/pending masks
// ISSUE | each bank serves its lowest pending lane (accumulate: read, then write-back)
// WAIT  | last read data returns from the RAM (1-cycle latency)
// RESP  | response held stable until rsp_ready
module banked_vector_ram #(
  parameter int LANES      = 4,
  parameter int BANKS      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  banked_vector_ram_if.slave     bus,
  output logic [31:0]            stat_conflict_cycles
);

  localparam int BB     = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BW     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int BDEPTH = DEPTH / BANKS;
  localparam int RW     = (BDEPTH > 1) ? $clog2(BDEPTH) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic [BW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    return BW'(a & ADDR_WIDTH'(BANKS - 1));
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
    return RW'(a >> BB);
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [LANES-1:0]        err_q, err_d;
  logic [LANES-1:0]        pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]   addr_q [LANES];
  logic [ADDR_WIDTH-1:0]   addr_d [LANES];
  logic [DATA_WIDTH-1:0]   wdata_q [LANES];
  logic [DATA_WIDTH-1:0]   wdata_d [LANES];
  logic [DATA_WIDTH-1:0]   rsp_data_q [LANES];
  logic [DATA_WIDTH-1:0]   rsp_data_d [LANES];
  logic [BANKS-1:0]        acc_wb_q, acc_wb_d;
  logic [LW-1:0]           acc_lane_q [BANKS];
  logic [LW-1:0]           acc_lane_d [BANKS];
  logic [BANKS-1:0]        cap_q, cap_d;
  logic [LW-1:0]           cap_lane_q [BANKS];
  logic [LW-1:0]           cap_lane_d [BANKS];
  logic [31:0]             stat_q, stat_d;
  logic                    first_q, first_d;

  logic [DATA_WIDTH-1:0]   mem [BANKS][BDEPTH];
  logic [DATA_WIDTH-1:0]   ram_rdata_q [BANKS];
  logic [BANKS-1:0]        ram_we, ram_re;
  logic [RW-1:0]           ram_row [BANKS];
  logic [DATA_WIDTH-1:0]   ram_wdata [BANKS];

  logic                    is_write, is_acc;
  logic                    found;
  logic [LW-1:0]           sel;

  assign is_write = (op_q == 2'd1);
  assign is_acc   = (op_q == 2'd2);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mask_d     = mask_q;
    err_d      = err_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    acc_wb_d   = '0;
    acc_lane_d = acc_lane_q;
    cap_d      = '0;
    cap_lane_d = cap_lane_q;
    stat_d     = stat_q;
    first_d    = first_q;
    ram_we     = '0;
    ram_re     = '0;
    found      = 1'b0;
    sel        = '0;
    for (int b = 0; b < BANKS; b++) begin
      ram_row[b]   = '0;
      ram_wdata[b] = '0;
    end

    // Read data issued last cycle lands in its lane; this also covers the WAIT cycle.
    for (int b = 0; b < BANKS; b++) begin
      if (cap_q[b]) rsp_data_d[cap_lane_q[b]] = ram_rdata_q[b];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d   = bus.req_op;
          mask_d = bus.req_mask;
          for (int i = 0; i < LANES; i++) begin
            addr_d[i]     = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d[i]    = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            err_d[i]      = mask_d[i] && (32'(addr_d[i]) >= 32'(DEPTH));
            rsp_data_d[i] = '0;
          end
          pending_d = mask_d & ~err_d;
          first_d   = 1'b1;
          state_d   = (pending_d == '0) ? S_RESP : S_ISSUE;
        end
      end

      S_ISSUE: begin
        first_d = 1'b0;
        // Every issue cycle beyond the first is a cycle lost to bank conflicts.
        if (!first_q && (stat_q != '1)) stat_d = stat_q + 32'd1;
        for (int b = 0; b < BANKS; b++) begin
          if (acc_wb_q[b]) begin
            ram_we[b]                   = 1'b1;
            ram_row[b]                  = row_of(addr_q[acc_lane_q[b]]);
            ram_wdata[b]                = ram_rdata_q[b] + wdata_q[acc_lane_q[b]];
            rsp_data_d[acc_lane_q[b]]   = ram_rdata_q[b];
            pending_d[acc_lane_q[b]]    = 1'b0;
          end else begin
            found = 1'b0;
            sel   = '0;
            for (int i = LANES - 1; i >= 0; i--) begin
              if (pending_q[i] && (bank_of(addr_q[i]) == BW'(b))) begin
                found = 1'b1;
                sel   = LW'(i);
              end
            end
            if (found) begin
              ram_row[b] = row_of(addr_q[sel]);
              if (is_acc) begin
                ram_re[b]     = 1'b1;
                acc_wb_d[b]   = 1'b1;
                acc_lane_d[b] = sel;
              end else if (is_write) begin
                ram_we[b]      = 1'b1;
                ram_wdata[b]   = wdata_q[sel];
                pending_d[sel] = 1'b0;
              end else begin
                ram_re[b]      = 1'b1;
                cap_d[b]       = 1'b1;
                cap_lane_d[b]  = sel;
                pending_d[sel] = 1'b0;
              end
            end
          end
        end
        if (pending_d == '0) state_d = S_WAIT;
      end

      S_WAIT: state_d = S_RESP;

      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Nothing new reaches the RAM on a reset edge.
    if (!rst_n) begin
      ram_we = '0;
      ram_re = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mask_q    <= '0;
      err_q     <= '0;
      pending_q <= '0;
      acc_wb_q  <= '0;
      cap_q     <= '0;
      stat_q    <= '0;
      first_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        addr_q[i]     <= '0;
        wdata_q[i]    <= '0;
        rsp_data_q[i] <= '0;
      end
      for (int b = 0; b < BANKS; b++) begin
        acc_lane_q[b] <= '0;
        cap_lane_q[b] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
      acc_wb_q   <= acc_wb_d;
      cap_q      <= cap_d;
      stat_q     <= stat_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      acc_lane_q <= acc_lane_d;
      cap_lane_q <= cap_lane_d;
    end
  end

  // Banks are plain single-port RAMs: contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (ram_we[b]) mem[b][ram_row[b]] <= ram_wdata[b];
      if (ram_re[b]) ram_rdata_q[b] <= mem[b][ram_row[b]];
    end
  end

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.rsp_valid        = (state_q == S_RESP);
  assign bus.rsp_mask         = mask_q;
  assign bus.rsp_err          = err_q;
  assign stat_conflict_cycles = stat_q;

  for (genvar i = 0; i < LANES; i++) begin : g_rsp
    assign bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data_q[i];
  end

endmodule

// File: tb/tb_banked_vector_ram.sv
// Randomized bench for banked_vector_ram: a lane-ordered array model predicts
// data, errors, latency and the conflict counter for every request.
module tb_banked_vector_ram;

  localparam int LANES = 4;
  localparam int BANKS = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stat;

  always #5 clk = ~clk;

  banked_vector_ram_if #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  banked_vector_ram #(
    .LANES(LANES), .BANKS(BANKS), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus_if),
    .stat_conflict_cycles (stat)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    ref_mem [DEPTH];
  logic [31:0]      ref_stat = 32'd0;

  logic [1:0]       t_op;
  logic [LANES-1:0] t_mask;
  int               t_addr [LANES];
  logic [DW-1:0]    t_wdata [LANES];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] op, input logic [LANES-1:0] mask,
                         input int a0, input int a1, input int a2, input int a3,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    t_op = op; t_mask = mask;
    t_addr[0] = a0; t_addr[1] = a1; t_addr[2] = a2; t_addr[3] = a3;
    t_wdata[0] = d0; t_wdata[1] = d1; t_wdata[2] = d2; t_wdata[3] = d3;
  endtask

  // Sends t_* as one request, predicts the outcome, holds rsp_ready low for
  // 'stall' cycles, then completes the handshake.
  task automatic run_req(input int stall);
    logic [DW-1:0]       exp_data [LANES];
    logic [LANES*DW-1:0] exp_flat;
    logic [LANES-1:0]    exp_err, pend;
    int                  cost [BANKS];
    int                  k, lat, n, a;

    for (int b = 0; b < BANKS; b++) cost[b] = 0;
    exp_err = '0;
    pend    = '0;
    for (int i = 0; i < LANES; i++) begin
      exp_data[i] = '0;
      if (t_mask[i]) begin
        a = t_addr[i];
        if (a >= DEPTH) exp_err[i] = 1'b1;
        else begin
          pend[i] = 1'b1;
          cost[a % BANKS] += (t_op == 2'd2) ? 2 : 1;
          case (t_op)
            2'd1: ref_mem[a] = t_wdata[i];
            2'd2: begin
              exp_data[i] = ref_mem[a];
              ref_mem[a]  = ref_mem[a] + t_wdata[i];
            end
            default: exp_data[i] = ref_mem[a];
          endcase
        end
      end
    end
    k = 0;
    for (int b = 0; b < BANKS; b++) if (cost[b] > k) k = cost[b];
    lat = (pend == '0) ? 1 : k + 2;
    if (pend != '0) ref_stat = ref_stat + 32'(k - 1);
    for (int i = 0; i < LANES; i++) exp_flat[i*DW +: DW] = exp_data[i];

    bus_if.req_op   = t_op;
    bus_if.req_mask = t_mask;
    for (int i = 0; i < LANES; i++) begin
      bus_if.req_addr[i*AW +: AW]  = AW'(t_addr[i]);
      bus_if.req_wdata[i*DW +: DW] = t_wdata[i];
    end
    bus_if.req_valid = 1'b1;
    chk("req_ready_idle", 128'(bus_if.req_ready), 128'd1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;

    n = 1;
    while (!bus_if.rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 128'(n), 128'(lat));
    for (int i = 0; i < LANES; i++)
      chk($sformatf("rsp_data_lane%0d", i), 128'(bus_if.rsp_data[i*DW +: DW]), 128'(exp_data[i]));
    chk("rsp_mask", 128'(bus_if.rsp_mask), 128'(t_mask));
    chk("rsp_err", 128'(bus_if.rsp_err), 128'(exp_err));

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 128'(bus_if.rsp_valid), 128'd1);
      chk("stall_req_ready", 128'(bus_if.req_ready), 128'd0);
      chk("stall_data", 128'(bus_if.rsp_data), 128'(exp_flat));
      chk("stall_err", 128'(bus_if.rsp_err), 128'(exp_err));
    end

    bus_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 128'(bus_if.rsp_valid), 128'd0);
    chk("req_ready_after_hs", 128'(bus_if.req_ready), 128'd1);
    chk("stat", 128'(stat), 128'(ref_stat));
  endtask

  initial begin
    int stall;
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = '0;
    bus_if.req_mask  = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(bus_if.req_ready), 128'd1);
    chk("rst_rsp_valid", 128'(bus_if.rsp_valid), 128'd0);
    chk("rst_rsp_data", 128'(bus_if.rsp_data), 128'd0);
    chk("rst_rsp_mask", 128'(bus_if.rsp_mask), 128'd0);
    chk("rst_rsp_err", 128'(bus_if.rsp_err), 128'd0);
    chk("rst_stat", 128'(stat), 128'd0);
    rst_n = 1'b1;

    set_req(2'd1, 4'hF, 0, 1, 2, 3, 32'd10, 32'd11, 32'd12, 32'd13);
    run_req(0);
    set_req(2'd0, 4'hF, 0, 1, 2, 3, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(0);
    chk("stat_after_two", 128'(stat), 128'd2);

    for (int j = 1; j < 16; j++) begin
      set_req(2'd1, 4'hF, 4*j, 4*j+1, 4*j+2, 4*j+3,
              $urandom, $urandom, $urandom, $urandom);
      run_req(0);
    end

    set_req(2'd0, 4'hF, 0, 2, 4, 6, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(0);

    set_req(2'd1, 4'h1, 5, 0, 0, 0, 32'd100, 32'd0, 32'd0, 32'd0);
    run_req(0);
    set_req(2'd2, 4'hF, 5, 5, 5, 5, 32'd1, 32'd2, 32'd3, 32'd4);
    run_req(0);
    set_req(2'd0, 4'h1, 5, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(0);
    chk("acc_final_110", 128'(ref_mem[5]), 128'd110);

    set_req(2'd1, 4'b0110, 7, 7, 7, 7, 32'd1, 32'd2, 32'd3, 32'd4);
    run_req(0);
    set_req(2'd0, 4'h1, 7, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(0);

    set_req(2'd0, 4'hF, 1, 1024, 3, 2000, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(0);
    set_req(2'd0, 4'h0, 1, 2, 3, 4, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(0);

    set_req(2'd3, 4'hF, 8, 8, 9, 9, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(20);

    for (int r = 0; r < 150; r++) begin
      t_op   = 2'($urandom_range(0, 3));
      t_mask = LANES'($urandom);
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 7) == 0) t_addr[i] = $urandom_range(1024, 2047);
        else if ($urandom_range(0, 1) == 0) t_addr[i] = $urandom_range(0, 7);
        else t_addr[i] = $urandom_range(0, 63);
        t_wdata[i] = $urandom;
      end
      stall = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 2);
      run_req(stall);
    end

    // Reset in the middle of a conflicting read: no response, counter cleared.
    bus_if.req_op   = 2'd0;
    bus_if.req_mask = 4'hF;
    for (int i = 0; i < LANES; i++) bus_if.req_addr[i*AW +: AW] = AW'(2 * i);
    bus_if.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rsp_valid", 128'(bus_if.rsp_valid), 128'd0);
    chk("midrst_req_ready", 128'(bus_if.req_ready), 128'd1);
    chk("midrst_stat", 128'(stat), 128'd0);
    rst_n = 1'b1;
    ref_stat = 32'd0;

    set_req(2'd0, 4'hF, 0, 2, 5, 7, 32'd0, 32'd0, 32'd0, 32'd0);
    run_req(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
